controle_pagamento: RTL and testbench
=====================================

// Module: controle_pagamento
// PURPOSE
//  Sequencer for the note-entry decoder. It opens the entry window by driving state_entrada=3'b000.
//  It accepts one decoded note per ok press, accumulates the credit against a latched price, and
//  decides between dispense-with-change and full refund (cancel or inactivity timeout).
//  It sits between the user keys/price source and the decoder (valor_saida/erro_code feed back in).
// PARAMETERS
//  LARGURA  8   width of preco/valor_nota; total and troco are LARGURA+1 bits
//  TIMEOUT  16  clk cycles without a note press in COLETA before automatic refund (>=2)
// PORTS
//  clk            in   1          single clock, rising edge
//  rst_n          in   1          synchronous reset, active-low
//  iniciar        in   1          start a purchase (level, sampled in IDLE only)
//  cancelar       in   1          abort purchase, refund credit (sampled in COLETA only)
//  ok             in   1          note confirm key; one note per rising edge of ok
//  preco          in   LARGURA    price, latched on accepted iniciar
//  valor_nota     in   LARGURA    decoded note value (decoder valor_saida)
//  nota_rejeitada in   1          decoder erro_code[0]; 1 = note not accepted
//  state_entrada  out  3          FSM state code, drives the decoder state input
//  total          out  LARGURA+1  accumulated credit
//  troco          out  LARGURA+1  change (dispense) or refund amount (devolve)
//  liberar        out  1          1-cycle dispense strobe
//  devolver       out  1          1-cycle refund strobe
//  erro           out  1          1-cycle error strobe (rejected note or zero price)
// BEHAVIOUR
//  States / state_entrada codes:
//   COLETA=000, IDLE=001, TROCO=010, LIBERA=011, DEVOLVE=100.
//   The decoder is active only in COLETA.
//  Reset (rst_n=0 at an edge): state IDLE; total, troco, timer and ok_q = 0; all strobes 0.
//   Reset mid-purchase aborts silently: no liberar or devolver.
//  ok edge detection: press = ok & ~ok_q, with ok_q registered every cycle. A held ok counts once.
//  IDLE:
//   - iniciar=1 and preco!=0 -> COLETA. Latch preco_reg=preco; total=0; troco=0; timer=0.
//   - iniciar=1 and preco==0 -> stay IDLE; erro=1 for one cycle.
//  COLETA (priority order, evaluated each edge):
//   1. cancelar=1 -> DEVOLVE. A press in the same cycle is ignored.
//   2. press and nota_rejeitada=1 -> erro=1 for one cycle; total unchanged; timer=0.
//   3. press and valor_nota==0 -> no-op; timer not cleared.
//   4. press with a valid note -> total <= total+valor_nota (zero-extended, no overflow in LARGURA+1 bits); timer=0.
//      If total+valor_nota >= preco_reg -> TROCO at the same edge.
//   5. No press -> timer+1. At timer==TIMEOUT-1 -> DEVOLVE.
//  TROCO: troco <= total - preco_reg -> LIBERA (one cycle).
//  LIBERA: liberar=1 (Moore, exactly one cycle) -> IDLE.
//   Latency: liberar is high on the 2nd cycle after the accepting edge.
//  DEVOLVE: troco <= total on entry; devolver=1 for exactly one cycle -> IDLE.
//  total and troco hold their values in IDLE until the next accepted iniciar.
//  cancelar, ok and iniciar are ignored in TROCO, LIBERA and DEVOLVE.
//   iniciar is ignored outside IDLE.
//  erro and liberar/devolver are never high in the same cycle.
// TESTING
//  1. preco=15; notes 10 then 10 -> total=20, TROCO, then liberar=1 for 1 cycle, troco=5, then IDLE.
//  2. preco=12; notes 5,5,2 -> total=12, liberar pulse, troco=0.
//  3. COLETA, code vinte (valor 20, nota_rejeitada=1) + ok -> erro 1 cycle, total unchanged, stay COLETA.
//  4. preco=50; notes 5,2 then cancelar -> devolver 1 cycle, troco=7, state_entrada=001.
//  5. TIMEOUT=16; after note 10, no ok for 16 cycles -> devolver on timeout, troco=10.
//     A second run with a press at cycle 15 restarts the timer.
//  6. ok held high 5 cycles with note 5 -> total=5 once.
//     rst_n=0 mid-COLETA -> IDLE, total=0, no strobes.
//     iniciar with preco=0 -> erro 1 cycle, remain IDLE.

Source files
------------

// File: rtl/controle_pagamento.sv
// controle_pagamento: purchase sequencer that collects decoded notes against a latched price
// and ends each purchase with either a dispense (with change) or a full refund.
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   iniciar, preco  : start request and price (latched when the purchase opens)
//   cancelar, ok    : abort key and note-confirm key (one note per rising edge of ok)
//   valor_nota      : decoded note value; nota_rejeitada flags a note the decoder refused
//   state_entrada   : state code fed back to the decoder (decoder active in COLETA = 000)
//   total, troco    : accumulated credit and change/refund amount
//   liberar, devolver, erro : one-cycle dispense, refund and error strobes
module controle_pagamento #(
    parameter int LARGURA = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iniciar,
    input  logic               cancelar,
    input  logic               ok,
    input  logic [LARGURA-1:0] preco,
    input  logic [LARGURA-1:0] valor_nota,
    input  logic               nota_rejeitada,
    output logic [2:0]         state_entrada,
    output logic [LARGURA:0]   total,
    output logic [LARGURA:0]   troco,
    output logic               liberar,
    output logic               devolver,
    output logic               erro
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        COLETA  = 3'b000,
        IDLE    = 3'b001,
        TROCO   = 3'b010,
        LIBERA  = 3'b011,
        DEVOLVE = 3'b100
    } estado_t;

    estado_t            state_q, state_d;
    logic [LARGURA-1:0] preco_q, preco_d;
    logic [LARGURA:0]   total_q, total_d;
    logic [LARGURA:0]   troco_q, troco_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               erro_q, erro_d;
    logic               ok_q;
    logic               press;
    logic [LARGURA:0]   soma;

    // A held ok key counts as a single press
    assign press = ok & ~ok_q;
    assign soma  = total_q + {1'b0, valor_nota};

    always_comb begin
        state_d = state_q;
        preco_d = preco_q;
        total_d = total_q;
        troco_d = troco_q;
        timer_d = timer_q;
        erro_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iniciar) begin
                    if (preco != '0) begin
                        state_d = COLETA;
                        preco_d = preco;
                        total_d = '0;
                        troco_d = '0;
                        timer_d = '0;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            COLETA: begin
                if (cancelar) begin
                    state_d = DEVOLVE;
                    troco_d = total_q;
                end else if (press && nota_rejeitada) begin
                    erro_d  = 1'b1;
                    timer_d = '0;
                end else if (press) begin
                    // A zero-valued note is a press that neither credits nor restarts the timer
                    if (valor_nota != '0) begin
                        total_d = soma;
                        timer_d = '0;
                        if (soma >= {1'b0, preco_q}) state_d = TROCO;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = DEVOLVE;
                    troco_d = total_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TROCO: begin
                troco_d = total_q - {1'b0, preco_q};
                state_d = LIBERA;
            end
            LIBERA:  state_d = IDLE;
            DEVOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            preco_q <= '0;
            total_q <= '0;
            troco_q <= '0;
            timer_q <= '0;
            erro_q  <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            preco_q <= preco_d;
            total_q <= total_d;
            troco_q <= troco_d;
            timer_q <= timer_d;
            erro_q  <= erro_d;
            ok_q    <= ok;
        end
    end

    assign state_entrada = state_q;
    assign total         = total_q;
    assign troco         = troco_q;
    assign liberar       = (state_q == LIBERA);
    assign devolver      = (state_q == DEVOLVE);
    assign erro          = erro_q;
endmodule

// File: tb/tb_controle_pagamento.sv
// tb_controle_pagamento: directed self-checking bench for controle_pagamento
module tb_controle_pagamento;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic       ok = 1'b0;
    logic [7:0] preco = '0;
    logic [7:0] valor_nota = '0;
    logic       nota_rejeitada = 1'b0;
    logic [2:0] state_entrada;
    logic [8:0] total;
    logic [8:0] troco;
    logic       liberar;
    logic       devolver;
    logic       erro;
    int checks = 0;
    int failures = 0;
    int lib_cnt = 0;
    int dev_cnt = 0;
    int err_cnt = 0;

    controle_pagamento #(.LARGURA(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .iniciar(iniciar), .cancelar(cancelar), .ok(ok),
        .preco(preco), .valor_nota(valor_nota), .nota_rejeitada(nota_rejeitada),
        .state_entrada(state_entrada), .total(total), .troco(troco),
        .liberar(liberar), .devolver(devolver), .erro(erro)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (liberar) lib_cnt++;
        if (devolver) dev_cnt++;
        if (erro) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] p);
        preco = p;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    task automatic note(input logic [7:0] v, input logic r);
        valor_nota = v;
        nota_rejeitada = r;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (state_entrada !== 3'b001) begin failures++; $display("FAIL reset_state got=%b exp=001", state_entrada); end
        checks++; if (total !== 9'd0) begin failures++; $display("FAIL reset_total got=%0d exp=0", total); end
        checks++; if (troco !== 9'd0) begin failures++; $display("FAIL reset_troco got=%0d exp=0", troco); end
        checks++; if ({liberar, devolver, erro} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {liberar, devolver, erro}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dispense_change();
        int l0;
        l0 = lib_cnt;
        start(8'd15);
        checks++; if (state_entrada !== 3'b000) begin failures++; $display("FAIL t1_coleta got=%b exp=000", state_entrada); end
        note(8'd10, 1'b0);
        checks++; if (total !== 9'd10) begin failures++; $display("FAIL t1_total10 got=%0d exp=10", total); end
        valor_nota = 8'd10;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        checks++; if (state_entrada !== 3'b010 || liberar !== 1'b0) begin failures++; $display("FAIL t1_troco_state got=%b lib=%b exp=010 lib=0", state_entrada, liberar); end
        checks++; if (total !== 9'd20) begin failures++; $display("FAIL t1_total20 got=%0d exp=20", total); end
        tick();
        checks++; if (state_entrada !== 3'b011 || liberar !== 1'b1) begin failures++; $display("FAIL t1_libera got=%b lib=%b exp=011 lib=1", state_entrada, liberar); end
        checks++; if (troco !== 9'd5) begin failures++; $display("FAIL t1_troco got=%0d exp=5", troco); end
        tick();
        checks++; if (state_entrada !== 3'b001 || liberar !== 1'b0) begin failures++; $display("FAIL t1_idle got=%b lib=%b exp=001 lib=0", state_entrada, liberar); end
        checks++; if (total !== 9'd20 || troco !== 9'd5) begin failures++; $display("FAIL t1_hold got=%0d/%0d exp=20/5", total, troco); end
        checks++; if (lib_cnt - l0 !== 1) begin failures++; $display("FAIL t1_lib_cycles got=%0d exp=1", lib_cnt - l0); end
    endtask

    task automatic test_exact_price();
        start(8'd12);
        note(8'd5, 1'b0);
        note(8'd5, 1'b0);
        note(8'd2, 1'b0);
        checks++; if (state_entrada !== 3'b011 || liberar !== 1'b1) begin failures++; $display("FAIL t2_libera got=%b lib=%b exp=011 lib=1", state_entrada, liberar); end
        checks++; if (total !== 9'd12 || troco !== 9'd0) begin failures++; $display("FAIL t2_values got=%0d/%0d exp=12/0", total, troco); end
        tick();
        checks++; if (state_entrada !== 3'b001) begin failures++; $display("FAIL t2_idle got=%b exp=001", state_entrada); end
    endtask

    task automatic test_rejected_note();
        int e0;
        e0 = err_cnt;
        start(8'd30);
        note(8'd10, 1'b0);
        valor_nota = 8'd20;
        nota_rejeitada = 1'b1;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        nota_rejeitada = 1'b0;
        checks++; if (erro !== 1'b1) begin failures++; $display("FAIL t3_erro got=%b exp=1", erro); end
        checks++; if (total !== 9'd10 || state_entrada !== 3'b000) begin failures++; $display("FAIL t3_unchanged got=%0d st=%b exp=10 st=000", total, state_entrada); end
        tick();
        checks++; if (erro !== 1'b0 || err_cnt - e0 !== 1) begin failures++; $display("FAIL t3_erro_pulse got=%b cnt=%0d exp=0 cnt=1", erro, err_cnt - e0); end
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        tick();
    endtask

    task automatic test_cancel();
        int d0;
        d0 = dev_cnt;
        start(8'd50);
        note(8'd5, 1'b0);
        note(8'd2, 1'b0);
        cancelar = 1'b1;
        valor_nota = 8'd40;
        ok = 1'b1;
        tick();
        cancelar = 1'b0;
        ok = 1'b0;
        checks++; if (state_entrada !== 3'b100 || devolver !== 1'b1) begin failures++; $display("FAIL t4_devolve got=%b dev=%b exp=100 dev=1", state_entrada, devolver); end
        checks++; if (troco !== 9'd7 || total !== 9'd7) begin failures++; $display("FAIL t4_refund got=%0d/%0d exp=7/7", troco, total); end
        tick();
        checks++; if (state_entrada !== 3'b001 || devolver !== 1'b0) begin failures++; $display("FAIL t4_idle got=%b dev=%b exp=001 dev=0", state_entrada, devolver); end
        checks++; if (dev_cnt - d0 !== 1) begin failures++; $display("FAIL t4_dev_cycles got=%0d exp=1", dev_cnt - d0); end
    endtask

    task automatic test_timeout();
        start(8'd50);
        valor_nota = 8'd10;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checks++; if (state_entrada !== 3'b000 || devolver !== 1'b0) begin failures++; $display("FAIL t5_before_to got=%b dev=%b exp=000 dev=0", state_entrada, devolver); end
        tick();
        checks++; if (devolver !== 1'b1 || troco !== 9'd10) begin failures++; $display("FAIL t5_timeout got dev=%b troco=%0d exp dev=1 troco=10", devolver, troco); end
        tick();
        checks++; if (state_entrada !== 3'b001) begin failures++; $display("FAIL t5_idle got=%b exp=001", state_entrada); end
        start(8'd50);
        valor_nota = 8'd10;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        valor_nota = 8'd5;
        ok = 1'b1;
        tick();
        ok = 1'b0;
        tick();
        checks++; if (state_entrada !== 3'b000 || total !== 9'd15) begin failures++; $display("FAIL t5_restart got=%b total=%0d exp=000 total=15", state_entrada, total); end
        for (int i = 0; i < 14; i++) tick();
        checks++; if (state_entrada !== 3'b000) begin failures++; $display("FAIL t5_before_to2 got=%b exp=000", state_entrada); end
        tick();
        checks++; if (devolver !== 1'b1 || troco !== 9'd15) begin failures++; $display("FAIL t5_timeout2 got dev=%b troco=%0d exp dev=1 troco=15", devolver, troco); end
        tick();
    endtask

    task automatic test_held_ok_and_reset();
        int l0;
        int d0;
        start(8'd50);
        valor_nota = 8'd5;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        ok = 1'b0;
        tick();
        checks++; if (total !== 9'd5) begin failures++; $display("FAIL t6_held_ok got=%0d exp=5", total); end
        l0 = lib_cnt;
        d0 = dev_cnt;
        rst_n = 1'b0;
        tick();
        checks++; if (state_entrada !== 3'b001 || total !== 9'd0) begin failures++; $display("FAIL t6_mid_reset got=%b total=%0d exp=001 total=0", state_entrada, total); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (lib_cnt != l0 || dev_cnt != d0 || state_entrada !== 3'b001) begin failures++; $display("FAIL t6_silent got lib=%0d dev=%0d st=%b exp 0 0 001", lib_cnt - l0, dev_cnt - d0, state_entrada); end
    endtask

    task automatic test_zero_price();
        start(8'd0);
        checks++; if (erro !== 1'b1 || state_entrada !== 3'b001) begin failures++; $display("FAIL t7_zero_price got erro=%b st=%b exp erro=1 st=001", erro, state_entrada); end
        tick();
        checks++; if (erro !== 1'b0 || state_entrada !== 3'b001) begin failures++; $display("FAIL t7_erro_pulse got erro=%b st=%b exp erro=0 st=001", erro, state_entrada); end
    endtask

    initial begin
        test_reset();
        test_dispense_change();
        test_exact_price();
        test_rejected_note();
        test_cancel();
        test_timeout();
        test_held_ok_and_reset();
        test_zero_price();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
